// File: rtl/inf_pkg.sv
// inf_pkg: definitions shared by the interface-block family.
//   UNLOCKED / LOCKED : encodings of the arbiter's grant-lock state
//   clog2()           : ceiling log2 for sizing index and counter fields
package inf_pkg;

  localparam logic [0:0] UNLOCKED = 1'b0;
  localparam logic [0:0] LOCKED   = 1'b1;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  : per-port request vector
//   last : most recently served port; the search starts just above it
//   sel  : first requesting port found, wrapping modulo N_PORTS
//   any  : high when at least one request is present
module rr_pick
  import inf_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int PORT_W  = clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PORT_W-1:0]  last,
  output logic [PORT_W-1:0]  sel,
  output logic               any
);

  logic [PORT_W-1:0] idx;

  // Walk last+1, last+2, ... last+N_PORTS (mod N_PORTS); the final step lands
  // back on last itself, so a lone requester is always found.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      idx = PORT_W'((int'(last) + i) % N_PORTS);
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/inf_stream_arbiter.sv
// inf_stream_arbiter: merges N_PORTS valid/ready streams into one registered
// output stream tagged with its source port, granting bursts of up to
// MAX_BURST beats round-robin, with a sticky downstream-stall watchdog.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   in_data/valid/ready   : packed requester streams (port i at [i*WIDTH +: WIDTH])
//   out_data/port/valid   : registered output beat and its source port
//   out_ready             : downstream accept
//   stall_err             : set after STALL_LIMIT consecutive stalled cycles
//   beat_count            : output transfers since reset, modulo 2^32
module inf_stream_arbiter
  import inf_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int N_PORTS     = 4,
  parameter int PORT_W      = clog2(N_PORTS),
  parameter int MAX_BURST   = 4,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_PORTS*WIDTH-1:0]   in_data,
  input  logic [N_PORTS-1:0]         in_valid,
  output logic [N_PORTS-1:0]         in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [PORT_W-1:0]          out_port,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       stall_err,
  output logic [31:0]                beat_count
);

  localparam int BURST_W = clog2(MAX_BURST + 1);
  localparam int STALL_W = clog2(STALL_LIMIT + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_LIMIT);
  localparam logic [PORT_W-1:0]  LAST_INIT  = PORT_W'(N_PORTS - 1);

  logic [0:0]         state_q, state_d;
  logic [PORT_W-1:0]  cur_port_q, cur_port_d;
  logic [PORT_W-1:0]  last_port_q, last_port_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stall_err_q, stall_err_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [PORT_W-1:0]  out_port_q, out_port_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        beat_count_q, beat_count_d;

  logic [WIDTH-1:0]   port_data [N_PORTS];
  logic [PORT_W-1:0]  pick_sel;
  logic               pick_any;
  logic [PORT_W-1:0]  sel;
  logic               locked;
  logic               load_en;
  logic               xfer;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
    assign port_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N_PORTS (N_PORTS),
    .PORT_W  (PORT_W)
  ) u_pick (
    .req  (in_valid),
    .last (last_port_q),
    .sel  (pick_sel),
    .any  (pick_any)
  );

  assign locked  = (state_q == LOCKED);
  assign load_en = !out_valid_q || out_ready;
  assign sel     = locked ? cur_port_q : pick_sel;

  // While locked the granted port keeps ready even if its valid has dropped;
  // that idle cycle is what lets the FSM notice the burst has ended.
  always_comb begin
    in_ready = '0;
    if (!reset && load_en && (locked || pick_any)) begin
      in_ready[sel] = 1'b1;
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    state_d      = state_q;
    cur_port_d   = cur_port_q;
    last_port_d  = last_port_q;
    burst_cnt_d  = burst_cnt_q;
    out_data_d   = out_data_q;
    out_port_d   = out_port_q;
    out_valid_d  = out_valid_q;

    // in_ready requires load_en, so every transfer happens inside this branch.
    if (load_en) begin
      if (xfer) begin
        out_data_d  = port_data[sel];
        out_port_d  = sel;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end

      if (!locked) begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            last_port_d = sel;
          end else begin
            state_d     = LOCKED;
            cur_port_d  = sel;
            burst_cnt_d = BURST_W'(1);
          end
        end
      end else if (xfer) begin
        if (burst_cnt_q == BURST_LAST) begin
          state_d     = UNLOCKED;
          last_port_d = cur_port_q;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end else begin
        state_d     = UNLOCKED;
        last_port_d = cur_port_q;
        burst_cnt_d = '0;
      end
    end
  end

  // The error flag looks at the next count so it rises in the cycle right
  // after the STALL_LIMIT-th stalled cycle rather than one cycle later.
  always_comb begin
    stall_cnt_d = '0;
    if (out_valid_q && !out_ready) begin
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end
    stall_err_d  = stall_err_q || (stall_cnt_d == STALL_MAX);
    beat_count_d = beat_count_q + ((out_valid_q && out_ready) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= UNLOCKED;
      cur_port_q   <= '0;
      last_port_q  <= LAST_INIT;
      burst_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      stall_err_q  <= 1'b0;
      out_data_q   <= '0;
      out_port_q   <= '0;
      out_valid_q  <= 1'b0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_port_q   <= cur_port_d;
      last_port_q  <= last_port_d;
      burst_cnt_q  <= burst_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_err_q  <= stall_err_d;
      out_data_q   <= out_data_d;
      out_port_q   <= out_port_d;
      out_valid_q  <= out_valid_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_port   = out_port_q;
  assign out_valid  = out_valid_q;
  assign stall_err  = stall_err_q;
  assign beat_count = beat_count_q;

endmodule
